// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   ST_IDLE/ST_FETCH/ST_DRAIN : 2-bit fetch state encoding
//   RESET_PC_DEFAULT          : default first fetch address after reset
//   NOP_WORD                  : value held in the instruction buffer after reset
//   align_target()            : clears the byte-offset bits of a redirect target
package fetch_unit_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

   function automatic logic [31:0] align_target(input logic [31:0] target);
      return {target[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory and decode.
//   imem_req/imem_addr    : read request and word address (fetch -> memory)
//   imem_ack/imem_rdata   : read completion and data (memory -> fetch)
//   if_valid/if_instr/if_pc : fetched word and its PC (fetch -> decode)
//   if_ready              : decode accepts the current word (decode -> fetch)
// master = fetch unit side, slave = memory/decode side.
interface fetch_unit_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        if_ready;

   modport master (
      output imem_req, imem_addr, if_valid, if_instr, if_pc,
      input  imem_ack, imem_rdata, if_ready
   );

   modport slave (
      input  imem_req, imem_addr, if_valid, if_instr, if_pc,
      output imem_ack, imem_rdata, if_ready
   );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word reads to instruction memory, buffers the
// returned instruction for decode, and redirects on jumps/taken branches.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   pc                    : current fetch PC (feeds the external PC+4 adder)
//   pc_plus4              : pc + 4 from the external adder
//   jmp, jmp_target       : jump redirect (wins over branch)
//   br_taken, br_target   : taken-branch redirect
//   bus (master)          : imem request/ack bus and if_* decode handshake
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic         clk,
   input  logic         rst_n,
   output logic [31:0]  pc,
   input  logic [31:0]  pc_plus4,
   input  logic         jmp,
   input  logic [31:0]  jmp_target,
   input  logic         br_taken,
   input  logic [31:0]  br_target,
   fetch_unit_if.master bus
);

   logic [1:0]  state_q;
   logic [31:0] pc_q;
   logic [31:0] req_addr_q;
   logic        pending_q;

   logic        if_valid_q;
   logic [31:0] if_instr_q;
   logic [31:0] if_pc_q;

   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        ack_fire;

   assign redirect    = jmp | br_taken;
   assign redirect_pc = align_target(jmp ? jmp_target : br_target);

   always_comb begin
      imem_req = 1'b0;
      case (state_q)
         ST_FETCH: imem_req = pending_q | ~if_valid_q | bus.if_ready;
         // An abandoned request must still complete on the bus.
         ST_DRAIN: imem_req = 1'b1;
         default:  imem_req = 1'b0;
      endcase
   end

   // While a request is outstanding the address is frozen even if pc moves.
   assign imem_addr = pending_q ? req_addr_q : pc_q;
   assign ack_fire  = imem_req & bus.imem_ack;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         pc_q       <= RESET_PC;
         req_addr_q <= RESET_PC;
         pending_q  <= 1'b0;
      end else begin
         if (imem_req && !bus.imem_ack) begin
            pending_q  <= 1'b1;
            req_addr_q <= imem_addr;
         end else if (ack_fire) begin
            pending_q <= 1'b0;
         end

         case (state_q)
            ST_IDLE: begin
               state_q <= ST_FETCH;
               if (redirect) pc_q <= redirect_pc;
            end
            ST_FETCH: begin
               if (redirect) begin
                  pc_q    <= redirect_pc;
                  state_q <= (imem_req && !bus.imem_ack) ? ST_DRAIN : ST_FETCH;
               end else if (ack_fire) begin
                  pc_q <= pc_plus4;
               end
            end
            ST_DRAIN: begin
               if (redirect) pc_q <= redirect_pc;
               if (ack_fire) state_q <= ST_FETCH;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_valid_q <= 1'b0;
         if_instr_q <= NOP_WORD;
         if_pc_q    <= 32'h0000_0000;
      end else if (redirect) begin
         if_valid_q <= 1'b0;
      end else if (state_q == ST_FETCH && ack_fire) begin
         if_valid_q <= 1'b1;
         if_instr_q <= bus.imem_rdata;
         if_pc_q    <= pc_q;
      end else if (bus.if_ready) begin
         if_valid_q <= 1'b0;
      end
   end

   assign pc            = pc_q;
   assign bus.imem_req  = imem_req;
   assign bus.imem_addr = imem_addr;
   assign bus.if_valid  = if_valid_q;
   assign bus.if_instr  = if_instr_q;
   assign bus.if_pc     = if_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed reset/stall/drain sequences, a
// table of redirect vectors, and a randomized run checked against a stream model.
module tb_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        jmp;
   logic [31:0] jmp_target;
   logic        br_taken;
   logic [31:0] br_target;

   logic ready;
   logic ack_en;
   logic stray;

   int tests;
   int fails;

   fetch_unit_if bus ();

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
   endfunction

   // Memory answers a request when ack_en is high; stray forces an unsolicited ack.
   assign bus.imem_ack   = ack_en & (bus.imem_req | stray);
   assign bus.imem_rdata = mem_word(bus.imem_addr);
   assign bus.if_ready   = ready;
   assign pc_plus4       = pc + 32'd4;

   fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pc         (pc),
      .pc_plus4   (pc_plus4),
      .jmp        (jmp),
      .jmp_target (jmp_target),
      .br_taken   (br_taken),
      .br_target  (br_target),
      .bus        (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rand_target();
      if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      return 32'($urandom_range(0, 32'hFFF));
   endfunction

   typedef struct {
      logic        jmp;
      logic [31:0] jt;
      logic        br;
      logic [31:0] bt;
      logic [31:0] exp_pc;
      logic [31:0] exp_next;
   } redir_vec_t;

   redir_vec_t vecs [6];

   logic [31:0] exp_pc;
   logic        hold;
   logic [31:0] held_addr;
   int          accepted;

   initial begin
      tests = 0;
      fails = 0;
      accepted = 0;
      rst_n = 1'b0;
      jmp = 1'b0;
      jmp_target = '0;
      br_taken = 1'b0;
      br_target = '0;
      ready = 1'b1;
      ack_en = 1'b1;
      stray = 1'b0;

      vecs[0] = '{1'b1, 32'h0000_0100, 1'b1, 32'h0000_0200, 32'h0000_0100, 32'h0000_0104};
      vecs[1] = '{1'b0, 32'h0000_0000, 1'b1, 32'h0000_0200, 32'h0000_0200, 32'h0000_0204};
      vecs[2] = '{1'b1, 32'h0000_0103, 1'b0, 32'h0000_0000, 32'h0000_0100, 32'h0000_0104};
      vecs[3] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0000};
      vecs[4] = '{1'b0, 32'h0000_0000, 1'b1, 32'h0000_02A6, 32'h0000_02A4, 32'h0000_02A8};
      vecs[5] = '{1'b1, 32'h0000_0055, 1'b1, 32'h0000_0077, 32'h0000_0054, 32'h0000_0058};

      // Reset state and first fetches with zero-wait memory.
      repeat (2) @(posedge clk);
      #1;
      check("rst_pc", pc, 32'h0);
      check("rst_req", 32'(bus.imem_req), 32'h0);
      check("rst_valid", 32'(bus.if_valid), 32'h0);
      check("rst_instr", bus.if_instr, 32'h0);
      check("rst_if_pc", bus.if_pc, 32'h0);
      rst_n = 1'b1;
      #1;
      check("idle_req", 32'(bus.imem_req), 32'h0);
      tick();
      check("first_req", 32'(bus.imem_req), 32'h1);
      check("addr0", bus.imem_addr, 32'h0);
      tick();
      check("addr4", bus.imem_addr, 32'h4);
      check("valid0", 32'(bus.if_valid), 32'h1);
      check("if_pc0", bus.if_pc, 32'h0);
      check("instr0", bus.if_instr, mem_word(32'h0));
      tick();
      check("addr8", bus.imem_addr, 32'h8);
      check("if_pc4", bus.if_pc, 32'h4);

      // Pending request, then decode stalls for three cycles.
      ack_en = 1'b0;
      tick();
      check("pend_req", 32'(bus.imem_req), 32'h1);
      check("pend_addr", bus.imem_addr, 32'h8);
      check("pend_valid", 32'(bus.if_valid), 32'h0);
      ready = 1'b0;
      ack_en = 1'b1;
      tick();
      for (int k = 0; k < 3; k++) begin
         check("stall_req", 32'(bus.imem_req), 32'h0);
         check("stall_valid", 32'(bus.if_valid), 32'h1);
         check("stall_if_pc", bus.if_pc, 32'h8);
         check("stall_instr", bus.if_instr, mem_word(32'h8));
         tick();
      end
      ready = 1'b1;

      // Redirect table: priority, alignment and wrap.
      for (int i = 0; i < 6; i++) begin
         jmp = vecs[i].jmp;
         jmp_target = vecs[i].jt;
         br_taken = vecs[i].br;
         br_target = vecs[i].bt;
         tick();
         jmp = 1'b0;
         br_taken = 1'b0;
         #1;
         check("redir_pc", pc, vecs[i].exp_pc);
         check("redir_flush", 32'(bus.if_valid), 32'h0);
         check("redir_addr", bus.imem_addr, vecs[i].exp_pc);
         tick();
         check("redir_if_pc", bus.if_pc, vecs[i].exp_pc);
         check("redir_valid", 32'(bus.if_valid), 32'h1);
         check("redir_next", bus.imem_addr, vecs[i].exp_next);
      end

      // Branch while the request to 0x8 waits three cycles for its ack.
      jmp = 1'b1;
      jmp_target = 32'h8;
      tick();
      jmp = 1'b0;
      check("drain_setup", bus.imem_addr, 32'h8);
      ack_en = 1'b0;
      br_taken = 1'b1;
      br_target = 32'h200;
      tick();
      br_taken = 1'b0;
      check("drain_pc", pc, 32'h200);
      for (int k = 0; k < 3; k++) begin
         check("drain_req", 32'(bus.imem_req), 32'h1);
         check("drain_addr", bus.imem_addr, 32'h8);
         check("drain_valid", 32'(bus.if_valid), 32'h0);
         if (k < 2) tick();
      end
      ack_en = 1'b1;
      tick();
      check("drain_drop", 32'(bus.if_valid), 32'h0);
      check("drain_next", bus.imem_addr, 32'h200);
      tick();
      check("drain_if_pc", bus.if_pc, 32'h200);
      check("drain_instr", bus.if_instr, mem_word(32'h200));

      // Asynchronous reset during an outstanding request.
      ack_en = 1'b0;
      #1;
      check("pre_rst_req", 32'(bus.imem_req), 32'h1);
      check("pre_rst_valid", 32'(bus.if_valid), 32'h1);
      #1;
      rst_n = 1'b0;
      #1;
      check("arst_req", 32'(bus.imem_req), 32'h0);
      check("arst_valid", 32'(bus.if_valid), 32'h0);
      check("arst_pc", pc, 32'h0);
      check("arst_if_pc", bus.if_pc, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      ack_en = 1'b1;
      stray = 1'b1;
      #1;
      check("late_ack_req", 32'(bus.imem_req), 32'h0);
      tick();
      stray = 1'b0;
      check("late_ack_valid", 32'(bus.if_valid), 32'h0);
      check("late_ack_instr", bus.if_instr, 32'h0);
      check("restart_req", 32'(bus.imem_req), 32'h1);
      check("restart_addr", bus.imem_addr, 32'h0);

      // Randomized run: decode must see a sequential stream restarting at each target.
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      exp_pc = 32'h0;
      for (int c = 0; c < 3000; c++) begin
         ready = ($urandom_range(0, 9) < 7);
         ack_en = ($urandom_range(0, 9) < 5);
         begin
            int r;
            r = $urandom_range(0, 99);
            jmp = (r < 4);
            br_taken = (r >= 2 && r < 7);
         end
         jmp_target = rand_target();
         br_target = rand_target();
         #3;
         if (bus.if_valid && bus.if_ready) begin
            check("rnd_if_pc", bus.if_pc, exp_pc);
            check("rnd_instr", bus.if_instr, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            accepted++;
         end
         if (jmp || br_taken) exp_pc = (jmp ? jmp_target : br_target) & 32'hFFFF_FFFC;
         hold = bus.imem_req && !bus.imem_ack;
         held_addr = bus.imem_addr;
         if (bus.imem_req) check("rnd_align", 32'(bus.imem_addr[1:0]), 32'h0);
         tick();
         if (hold) check("rnd_hold", {31'(bus.imem_req), bus.imem_addr},
                         {31'h1, held_addr});
      end
      jmp = 1'b0;
      br_taken = 1'b0;
      check("rnd_progress", 32'(accepted > 100), 32'h1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
